// File: rtl/npc_mc_if.sv
// Instruction-fetch handshake between the npc_mc core and its fetch unit.
interface npc_mc_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        inst_valid;
  logic [31:0] inst;

  modport master (output ifu_req, output ifu_addr, input inst_valid, input inst);
  modport slave  (input ifu_req, input ifu_addr, output inst_valid, output inst);
endinterface

// File: rtl/npc_mc.sv
// npc_mc: multi-cycle RV32I-subset core (FETCH -> EXEC) with halt reporting.
//
// state   | meaning
// S_FETCH | ifu_req high; IR latched on the first edge with inst_valid
// S_EXEC  | decode/execute IR; retire, or trap to S_HALT, at the closing edge
// S_HALT  | stopped on ebreak/illegal/misaligned; left only through rst
module npc_mc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NR_REGS  = 32
) (
  input  logic            clk,
  input  logic            rst,
  npc_mc_if.master        ifu,
  output logic [31:0]     pc,
  output logic [31:0]     alu_result,
  output logic            commit,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic [31:0]     a0
);
  localparam int              IDX_W  = $clog2(NR_REGS);
  localparam logic [5:0]      NR     = 6'(NR_REGS);
  localparam logic [IDX_W-1:0] A0_IDX = IDX_W'(10);
  localparam logic [31:0]     EBREAK = 32'h0010_0073;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [31:0] regs [NR_REGS];
  logic [1:0]  code_q, code_nxt;
  logic        ir_load, wen, pc_en;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_u, imm_j, imm_b;
  logic [31:0] rs1_val, rs2_val, pc_inc, res, target, next_pc;
  logic        known, use_rd, use_rs1, use_rs2, is_jump, is_brk, taken;
  logic        illegal, misaligned;

  function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, sra;
    sra = $signed(a) >>> b[4:0];
    case (f)
      3'd0:    r = alt ? (a - b) : (a + b);
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? sra : (a >> b[4:0]);
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign f3      = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign f7      = ir[31:25];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_u   = {ir[31:12], 12'd0};
  assign imm_j   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_b   = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  // Out-of-range indices alias here, but such instructions trap before any use.
  assign rs1_val = regs[rs1[IDX_W-1:0]];
  assign rs2_val = regs[rs2[IDX_W-1:0]];
  assign pc_inc  = pc + 32'd4;

  // Decode and execute the instruction held in IR.
  always_comb begin
    known   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_jump = 1'b0;
    is_brk  = 1'b0;
    taken   = 1'b0;
    res     = '0;
    target  = pc + imm_b;
    case (opcode)
      OP_LUI:   begin known = 1'b1; use_rd = 1'b1; res = imm_u; end
      OP_AUIPC: begin known = 1'b1; use_rd = 1'b1; res = pc + imm_u; end
      OP_JAL: begin
        known = 1'b1; use_rd = 1'b1; is_jump = 1'b1;
        res = pc_inc; target = pc + imm_j;
      end
      OP_JALR: begin
        known = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; is_jump = 1'b1;
        res = pc_inc; target = (rs1_val + imm_i) & ~32'd1;
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'd1:    known = (f7 == 7'h00);
          3'd5:    known = (f7 == 7'h00) || (f7 == 7'h20);
          default: known = 1'b1;
        endcase
        res = alu(f3, (f3 == 3'd5) && f7[5], rs1_val, imm_i);
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        known = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        res = alu(f3, f7[5], rs1_val, rs2_val);
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        known = (f3 != 3'd2) && (f3 != 3'd3);
        res = target;
        case (f3)
          3'd0:    taken = (rs1_val == rs2_val);
          3'd1:    taken = (rs1_val != rs2_val);
          3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'd6:    taken = (rs1_val <  rs2_val);
          3'd7:    taken = (rs1_val >= rs2_val);
          default: taken = 1'b0;
        endcase
      end
      OP_SYSTEM: begin known = (ir == EBREAK); is_brk = known; end
      default: ;
    endcase
  end

  assign illegal    = !known || (use_rd  && ({1'b0, rd}  >= NR))
                             || (use_rs1 && ({1'b0, rs1} >= NR))
                             || (use_rs2 && ({1'b0, rs2} >= NR));
  assign misaligned = (is_jump || taken) && target[1];
  assign next_pc    = (is_jump || taken) ? target : pc_inc;

  // Next-state and control: traps take priority over retirement.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    ir_load   = 1'b0;
    commit    = 1'b0;
    wen       = 1'b0;
    pc_en     = 1'b0;
    case (state)
      S_FETCH: begin
        if (ifu.inst_valid) begin
          ir_load   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (illegal) begin
          state_nxt = S_HALT; code_nxt = 2'b10;
        end else if (misaligned) begin
          state_nxt = S_HALT; code_nxt = 2'b11;
        end else if (is_brk) begin
          commit = 1'b1; state_nxt = S_HALT; code_nxt = 2'b01;
        end else begin
          commit    = 1'b1;
          wen       = use_rd && (rd != 5'd0);
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT:  ;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, PC, IR and halt code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      code_q <= 2'b00;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      if (ir_load) ir <= ifu.inst;
      if (pc_en)   pc <= next_pc;
    end
  end

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[rd[IDX_W-1:0]] <= res;
    end
  end

  assign ifu.ifu_req  = (state == S_FETCH);
  assign ifu.ifu_addr = pc;
  assign alu_result   = res;
  assign halt         = (state == S_HALT);
  assign halt_code    = code_q;
  assign a0           = regs[A0_IDX];
endmodule

// File: tb/tb_npc_mc.sv
// Self-checking bench for npc_mc: directed scenarios plus a random instruction
// stream checked against an instruction-level reference model.
module tb_npc_mc;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_mc_if if32 ();
  npc_mc_if if16 ();

  logic [31:0] pc32, alu32, a032, pc16, alu16, a016;
  logic        commit32, halt32, commit16, halt16;
  logic [1:0]  code32, code16;

  npc_mc #(.RESET_PC(RPC), .NR_REGS(32)) dut32 (
    .clk(clk), .rst(rst), .ifu(if32), .pc(pc32), .alu_result(alu32),
    .commit(commit32), .halt(halt32), .halt_code(code32), .a0(a032));

  npc_mc #(.RESET_PC(RPC), .NR_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .ifu(if16), .pc(pc16), .alu_result(alu16),
    .commit(commit16), .halt(halt16), .halt_code(code16), .a0(a016));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural state only.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  bit          m_halted;
  logic [1:0]  m_code;
  int          m_nr;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit e, input logic v, input logic [31:0] w);
    if (e) begin if16.inst_valid = v; if16.inst = w; end
    else   begin if32.inst_valid = v; if32.inst = w; end
  endtask

  // Present one instruction after some wait cycles; returns at the EXEC sample point.
  task automatic fetch(input bit e, input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin drive(e, 1'b0, $urandom()); tick(); end
    drive(e, 1'b1, w);
    tick();
    drive(e, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int nr);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = RPC; m_halted = 1'b0; m_code = 2'b00; m_nr = nr;
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs1, int rs2, int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'h6f};
  endfunction

  // Execute one instruction word on the model; reports the expected commit and result.
  task automatic model_exec(input logic [31:0] w, output bit ec, output logic [31:0] eres,
                            output bit chk);
    int vi, vb, vj, f3, f7, rd, r1, r2;
    logic [31:0] a, b, immi, tgt, npc, sra;
    bit ill, brk, wr, jump, u1, u2;
    f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    rd = int'(w[11:7]); r1 = int'(w[19:15]); r2 = int'(w[24:20]);
    a = m_regs[r1]; b = m_regs[r2];
    vi = int'(w[31:20]); if (vi >= 2048) vi -= 4096;
    vb = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    if (w[31]) vb -= 8192;
    vj = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    if (w[31]) vj -= 2097152;
    immi = vi;
    ill = 0; brk = 0; wr = 0; jump = 0; u1 = 0; u2 = 0;
    eres = '0; tgt = '0; npc = m_pc + 4;
    case (w[6:0])
      7'h37: begin wr = 1; eres = w & 32'hffff_f000; end
      7'h17: begin wr = 1; eres = m_pc + (w & 32'hffff_f000); end
      7'h6f: begin wr = 1; jump = 1; tgt = m_pc + vj; eres = m_pc + 4; end
      7'h67: begin
        wr = 1; u1 = 1; jump = 1; ill = (f3 != 0);
        tgt = (a + immi) & 32'hffff_fffe; eres = m_pc + 4;
      end
      7'h13: begin
        wr = 1; u1 = 1;
        sra = $signed(a) >>> (vi % 32 + 32) % 32;
        case (f3)
          0: eres = a + immi;
          2: eres = ($signed(a) < $signed(immi)) ? 1 : 0;
          3: eres = (a < immi) ? 1 : 0;
          4: eres = a ^ immi;
          6: eres = a | immi;
          7: eres = a & immi;
          1: begin ill = (f7 != 0); eres = a << int'(w[24:20]); end
          default: begin
            sra = $signed(a) >>> int'(w[24:20]);
            if (f7 == 0) eres = a >> int'(w[24:20]);
            else if (f7 == 32) eres = sra;
            else ill = 1;
          end
        endcase
      end
      7'h33: begin
        wr = 1; u1 = 1; u2 = 1;
        sra = $signed(a) >>> (b % 32);
        if (f7 == 0) begin
          case (f3)
            0: eres = a + b;
            1: eres = a << (b % 32);
            2: eres = ($signed(a) < $signed(b)) ? 1 : 0;
            3: eres = (a < b) ? 1 : 0;
            4: eres = a ^ b;
            5: eres = a >> (b % 32);
            6: eres = a | b;
            default: eres = a & b;
          endcase
        end else if (f7 == 32 && f3 == 0) eres = a - b;
        else if (f7 == 32 && f3 == 5) eres = sra;
        else ill = 1;
      end
      7'h63: begin
        u1 = 1; u2 = 1; tgt = m_pc + vb; eres = tgt;
        case (f3)
          0: jump = (a == b);
          1: jump = (a != b);
          4: jump = ($signed(a) < $signed(b));
          5: jump = ($signed(a) >= $signed(b));
          6: jump = (a < b);
          7: jump = (a >= b);
          default: ill = 1;
        endcase
      end
      7'h73: begin if (w == 32'h0010_0073) brk = 1; else ill = 1; end
      default: ill = 1;
    endcase
    if ((wr && rd >= m_nr) || (u1 && r1 >= m_nr) || (u2 && r2 >= m_nr)) ill = 1;
    if (jump) npc = tgt;
    chk = 0;
    if (ill) begin ec = 0; m_halted = 1; m_code = 2'b10; end
    else if (jump && tgt[1]) begin ec = 0; m_halted = 1; m_code = 2'b11; end
    else if (brk) begin ec = 1; m_halted = 1; m_code = 2'b01; end
    else begin
      ec = 1; chk = 1;
      if (wr && rd != 0) m_regs[rd] = eres;
      m_pc = npc;
    end
  endtask

  function automatic logic [31:0] gen_inst();
    int k, off, f3, rd, r1, r2;
    logic [31:0] w;
    k = $urandom_range(0, 19);
    rd = $urandom_range(0, 31); r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31);
    f3 = $urandom_range(0, 7);
    off = 4 * $urandom_range(0, 31) - 64;
    if ($urandom_range(0, 7) == 0) off += 2;
    case (k)
      0, 1:        w = {20'($urandom()), 5'(rd), 7'h37};
      2:           w = {20'($urandom()), 5'(rd), 7'h17};
      3, 4, 5, 6: begin
        if (f3 == 1) w = enc_i($urandom_range(0, 31), r1, f3, rd);
        else if (f3 == 5) w = enc_i($urandom_range(0, 31) + ($urandom_range(0, 1) * 1024), r1, f3, rd);
        else w = enc_i($urandom_range(0, 4095), r1, f3, rd);
      end
      7, 8, 9, 10, 11:
        w = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, r2, r1, f3, rd);
      12, 13, 14: begin
        if (f3 == 2 || f3 == 3) f3 = 0;
        w = enc_b(off, r1, r2, f3);
      end
      15:          w = enc_j(off, rd);
      16:          w = {12'($urandom()), 5'(r1), 3'd0, 5'(rd), 7'h67};
      17:          w = 32'h0010_0073;
      default:     w = $urandom();
    endcase
    return w;
  endfunction

  task automatic test_reset();
    do_reset(32);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (pc32 !== RPC) begin n_err++; $display("FAIL reset_pc c=%0d got=%h exp=%h", c, pc32, RPC); end
      n_cmp++; if (if32.ifu_addr !== RPC) begin n_err++; $display("FAIL reset_ifu_addr c=%0d got=%h exp=%h", c, if32.ifu_addr, RPC); end
      n_cmp++; if (if32.ifu_req !== 1'b1) begin n_err++; $display("FAIL reset_ifu_req c=%0d got=%b exp=1", c, if32.ifu_req); end
      n_cmp++; if (commit32 !== 1'b0) begin n_err++; $display("FAIL reset_commit c=%0d got=%b exp=0", c, commit32); end
    end
    n_cmp++; if (halt32 !== 1'b0 || code32 !== 2'b00) begin n_err++; $display("FAIL reset_halt got=%b/%b exp=0/00", halt32, code32); end
    n_cmp++; if (a032 !== 32'h0) begin n_err++; $display("FAIL reset_a0 got=%h exp=0", a032); end
    fetch(0, 32'h0000_0013, 0);
    n_cmp++; if (commit32 !== 1'b1) begin n_err++; $display("FAIL nop_commit got=%b exp=1", commit32); end
    n_cmp++; if (if32.ifu_req !== 1'b0) begin n_err++; $display("FAIL nop_exec_req got=%b exp=0", if32.ifu_req); end
    tick();
    n_cmp++; if (commit32 !== 1'b0) begin n_err++; $display("FAIL nop_commit_pulse got=%b exp=0", commit32); end
    n_cmp++; if (if32.ifu_addr !== RPC + 4) begin n_err++; $display("FAIL nop_next_addr got=%h exp=%h", if32.ifu_addr, RPC + 4); end
  endtask

  task automatic test_addi_add();
    do_reset(32);
    fetch(0, 32'h0050_0093, 0);
    n_cmp++; if (alu32 !== 32'd5 || commit32 !== 1'b1) begin n_err++; $display("FAIL addi_result got=%h/%b exp=5/1", alu32, commit32); end
    tick();
    n_cmp++; if (if32.ifu_addr !== RPC + 4) begin n_err++; $display("FAIL addi_next got=%h exp=%h", if32.ifu_addr, RPC + 4); end
    fetch(0, 32'h0010_8133, 0);
    n_cmp++; if (alu32 !== 32'd10 || commit32 !== 1'b1) begin n_err++; $display("FAIL add_result got=%h/%b exp=a/1", alu32, commit32); end
    tick();
    n_cmp++; if (pc32 !== RPC + 8) begin n_err++; $display("FAIL add_pc got=%h exp=%h", pc32, RPC + 8); end
  endtask

  task automatic test_ebreak();
    do_reset(32);
    fetch(0, 32'h1234_5537, 1);
    tick();
    n_cmp++; if (a032 !== 32'h1234_5000) begin n_err++; $display("FAIL lui_a0 got=%h exp=12345000", a032); end
    fetch(0, 32'h0010_0073, 2);
    n_cmp++; if (commit32 !== 1'b1) begin n_err++; $display("FAIL ebreak_commit got=%b exp=1", commit32); end
    tick();
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (halt32 !== 1'b1 || code32 !== 2'b01) begin n_err++; $display("FAIL ebreak_halt c=%0d got=%b/%b exp=1/01", c, halt32, code32); end
      n_cmp++; if (pc32 !== RPC + 4) begin n_err++; $display("FAIL ebreak_pc c=%0d got=%h exp=%h", c, pc32, RPC + 4); end
      n_cmp++; if (if32.ifu_req !== 1'b0 || commit32 !== 1'b0) begin n_err++; $display("FAIL ebreak_idle c=%0d req=%b commit=%b exp=0/0", c, if32.ifu_req, commit32); end
      n_cmp++; if (a032 !== 32'h1234_5000) begin n_err++; $display("FAIL ebreak_a0 c=%0d got=%h exp=12345000", c, a032); end
      drive(0, 1'($urandom_range(0, 1)), 32'h0050_0513);
      tick();
    end
    drive(0, 1'b0, 32'h0);
  endtask

  task automatic test_control();
    do_reset(32);
    fetch(0, 32'h0000_0463, 0);
    n_cmp++; if (alu32 !== RPC + 8 || commit32 !== 1'b1) begin n_err++; $display("FAIL beq_target got=%h/%b exp=%h/1", alu32, commit32, RPC + 8); end
    tick();
    n_cmp++; if (if32.ifu_addr !== RPC + 8) begin n_err++; $display("FAIL beq_next got=%h exp=%h", if32.ifu_addr, RPC + 8); end

    do_reset(32);
    fetch(0, 32'h1010_0293, 0);
    tick();
    fetch(0, 32'h0002_80e7, 1);
    n_cmp++; if (alu32 !== RPC + 8) begin n_err++; $display("FAIL jalr_link got=%h exp=%h", alu32, RPC + 8); end
    tick();
    n_cmp++; if (pc32 !== 32'h0000_0100) begin n_err++; $display("FAIL jalr_pc got=%h exp=00000100", pc32); end
    fetch(0, 32'h0000_8513, 0);
    tick();
    n_cmp++; if (a032 !== RPC + 8) begin n_err++; $display("FAIL jalr_x1 got=%h exp=%h", a032, RPC + 8); end

    do_reset(32);
    fetch(0, enc_j(6, 1), 0);
    n_cmp++; if (commit32 !== 1'b0) begin n_err++; $display("FAIL jal_mis_commit got=%b exp=0", commit32); end
    tick();
    n_cmp++; if (halt32 !== 1'b1 || code32 !== 2'b11) begin n_err++; $display("FAIL jal_mis_code got=%b/%b exp=1/11", halt32, code32); end
    n_cmp++; if (pc32 !== RPC) begin n_err++; $display("FAIL jal_mis_pc got=%h exp=%h", pc32, RPC); end
  endtask

  task automatic test_rv32e();
    do_reset(16);
    fetch(1, 32'h0010_0813, 0);
    n_cmp++; if (commit16 !== 1'b0) begin n_err++; $display("FAIL e_x16_commit got=%b exp=0", commit16); end
    tick();
    n_cmp++; if (halt16 !== 1'b1 || code16 !== 2'b10) begin n_err++; $display("FAIL e_x16_code got=%b/%b exp=1/10", halt16, code16); end
    n_cmp++; if (pc16 !== RPC) begin n_err++; $display("FAIL e_x16_pc got=%h exp=%h", pc16, RPC); end

    do_reset(16);
    fetch(1, 32'h0010_0013, 0);
    n_cmp++; if (commit16 !== 1'b1) begin n_err++; $display("FAIL e_x0_commit got=%b exp=1", commit16); end
    tick();
    fetch(1, 32'h0000_0513, 0);
    n_cmp++; if (alu16 !== 32'h0) begin n_err++; $display("FAIL e_x0_read got=%h exp=0", alu16); end
    tick();
    n_cmp++; if (a016 !== 32'h0 || halt16 !== 1'b0) begin n_err++; $display("FAIL e_x0_a0 got=%h/%b exp=0/0", a016, halt16); end

    do_reset(16);
    fetch(1, 32'h0000_2003, 0);
    n_cmp++; if (commit16 !== 1'b0) begin n_err++; $display("FAIL e_lw_commit got=%b exp=0", commit16); end
    tick();
    n_cmp++; if (code16 !== 2'b10) begin n_err++; $display("FAIL e_lw_code got=%b exp=10", code16); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset(32);
    fetch(0, 32'h0000_0013, 0);
    tick();
    fetch(0, 32'h0070_0093, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc32 !== RPC) begin n_err++; $display("FAIL mid_rst_pc got=%h exp=%h", pc32, RPC); end
    n_cmp++; if (if32.ifu_req !== 1'b1 || commit32 !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl req=%b commit=%b exp=1/0", if32.ifu_req, commit32); end
    tick();
    rst = 1'b0;
    fetch(0, 32'h0000_8513, 0);
    n_cmp++; if (pc32 !== RPC || commit32 !== 1'b1) begin n_err++; $display("FAIL mid_rst_refetch got=%h/%b exp=%h/1", pc32, commit32, RPC); end
    n_cmp++; if (alu32 !== 32'h0) begin n_err++; $display("FAIL mid_rst_x1 got=%h exp=0", alu32); end
  endtask

  task automatic test_random();
    logic [31:0] w, eres;
    bit ec, chk;
    do_reset(32);
    for (int n = 0; n < 300; n++) begin
      w = gen_inst();
      fetch(0, w, $urandom_range(0, 2));
      n_cmp++; if (pc32 !== m_pc) begin n_err++; $display("FAIL rnd_exec_pc n=%0d inst=%h got=%h exp=%h", n, w, pc32, m_pc); end
      model_exec(w, ec, eres, chk);
      n_cmp++; if (commit32 !== ec) begin n_err++; $display("FAIL rnd_commit n=%0d inst=%h got=%b exp=%b", n, w, commit32, ec); end
      if (chk) begin
        n_cmp++; if (alu32 !== eres) begin n_err++; $display("FAIL rnd_result n=%0d inst=%h got=%h exp=%h", n, w, alu32, eres); end
      end
      tick();
      n_cmp++; if (pc32 !== m_pc) begin n_err++; $display("FAIL rnd_next_pc n=%0d inst=%h got=%h exp=%h", n, w, pc32, m_pc); end
      n_cmp++; if (halt32 !== m_halted || code32 !== m_code) begin n_err++; $display("FAIL rnd_halt n=%0d inst=%h got=%b/%b exp=%b/%b", n, w, halt32, code32, m_halted, m_code); end
      n_cmp++; if (a032 !== m_regs[10]) begin n_err++; $display("FAIL rnd_a0 n=%0d got=%h exp=%h", n, a032, m_regs[10]); end
      if (m_halted) begin
        n_cmp++; if (if32.ifu_req !== 1'b0) begin n_err++; $display("FAIL rnd_halt_req n=%0d got=%b exp=0", n, if32.ifu_req); end
        do_reset(32);
      end
    end
  endtask

  initial begin
    if32.inst_valid = 1'b0; if32.inst = '0;
    if16.inst_valid = 1'b0; if16.inst = '0;
    tick();
    test_reset();
    test_addi_add();
    test_ebreak();
    test_control();
    test_rv32e();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/npc_mc.md
# npc_mc

Multi-cycle, parametrised RV32I-subset core; successor to the single-cycle `npc`. It adds:
- a valid/ready-style instruction-fetch handshake that tolerates wait states;
- R-type, full OP-IMM and branch instructions;
- configurable register count (RV32E/RV32I) and reset PC;
- architectural halt reporting (ebreak, illegal, misaligned) on ports in place of a simulator callback.

It sits between the instruction memory/fetch unit and the simulation harness, which watches `halt`/`a0` for good/bad trap.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000, PC loaded on reset.
- `NR_REGS`, 32, register count; legal values 16 (RV32E) or 32.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ifu_req`  out  1  fetch request; high exactly in FETCH state.
- `ifu_addr`  out  32  fetch address, equals `pc`.
- `inst_valid`  in  1  fetch unit presents a valid `inst`.
- `inst`  in  32  fetched instruction word.
- `pc`  out  32  address of instruction being fetched/executed.
- `alu_result`  out  32  result of the instruction in EXEC (rd write data, or branch target for branches).
- `commit`  out  1  high for the single EXEC cycle of each retired instruction.
- `halt`  out  1  sticky; core stopped.
- `halt_code`  out  2  01 ebreak, 10 illegal instruction, 11 misaligned target; 00 while running.
- `a0`  out  32  live value of x10.

## Operation
- States: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: `ifu_req`=1, `ifu_addr`=`pc`.
  - On a rising edge with `inst_valid`=1: latch `inst` into the IR and go to EXEC.
  - Otherwise stay in FETCH; any number of wait cycles.
- EXEC: decode IR, compute, assert `commit`.
  - At the closing edge: write rd (if any), set `pc` to next PC, return to FETCH.
- `inst_valid` is ignored outside FETCH.
- Supported instructions:
  - lui, auipc, jal, jalr;
  - OP-IMM: addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
  - OP: add, sub, sll, slt, sltu, xor, srl, sra, or, and;
  - BRANCH: beq, bne, blt, bge, bltu, bgeu;
  - ebreak (32'h00100073).
- Immediates are sign-extended per the RV32I I/U/J/B formats. Arithmetic is mod 2^32. Shift amount is the low 5 bits of the operand. slt/blt/bge compare signed; sltu/bltu/bgeu compare unsigned.
- jal/jalr write pc+4 to rd. The jalr target is (rs1+imm) with bit0 cleared.
- Next PC: pc+4 by default; jal/jalr/taken-branch target otherwise. `alu_result` carries that target for branches.
- Writes to x0 are discarded; x0 always reads 0.
- Illegal (→ HALT, code 10):
  - any opcode/funct combination not listed, including loads, stores and fence;
  - any rd/rs1/rs2 index ≥ `NR_REGS`;
  - shift-immediate with inst[25]=1.
- Misaligned (→ HALT, code 11): jal, jalr or taken-branch target with bit1=1.
- On ebreak, illegal or misaligned, in EXEC:
  - no rd write; `pc` holds the faulting instruction's address;
  - `commit` is still asserted for ebreak, and not for illegal/misaligned.
- HALT is terminal until `rst`:
  - `ifu_req`=0, no register writes, `commit`=0;
  - `halt`=1, `halt_code` held.

## Timing
Reset values, applied asynchronously on `rst`:
- state=FETCH, `pc`=`RESET_PC`, all registers 0, IR 0;
- `ifu_req`=1, `commit`=0, `halt`=0, `halt_code`=00;
- `alu_result` reflects IR=0 and is not meaningful while `commit`=0.

Latency:
- Minimum 2 cycles per instruction: 1 FETCH with `inst_valid` already high, then 1 EXEC.
- Each fetch wait cycle adds 1.
- `ifu_addr` updates the cycle after EXEC.

Write visibility: rd written at the end of EXEC is readable by the next instruction's EXEC. No forwarding is needed in a multi-cycle core.

`a0` reflects x10 combinationally from the register array, so it updates the cycle after the writing EXEC.

Reset mid-operation (any state, including EXEC or HALT):
- immediate return to the reset values above;
- an instruction in EXEC does not write rd.

The transition to HALT takes effect at the EXEC closing edge. `halt` goes high the cycle after the offending EXEC.

## Test plan
- Reset, hold `inst_valid`=0 for 3 cycles → `pc`=`ifu_addr`=0x80000000, `ifu_req`=1, `commit`=0 throughout; on the 4th cycle present `inst_valid` with 32'h00000013 (nop) → one `commit` pulse, then `ifu_addr`=0x80000004.
- Zero-wait fetch of addi x1,x0,5 (0x00500093) then add x2,x1,x1 (0x00108133) → `alu_result`=5 then 10 on the respective `commit` cycles; 4 cycles total.
- lui x10,0x12345 (0x12345537), then ebreak → `a0`=0x12345000; after the ebreak EXEC: `halt`=1, `halt_code`=01, `pc`=0x80000004, `ifu_req`=0 for 10+ cycles; further `inst_valid` pulses have no effect.
- Control flow:
  - beq x0,x0,+8 (0x00000463) at 0x80000000 → next `ifu_addr`=0x80000008.
  - addi x5,x0,0x101 (0x10100293); jalr x1,0(x5) (0x000280e7) → `pc`=0x00000100, x1 = jalr address+4.
  - jal with offset +6 → `halt_code`=11, `pc` unchanged.
- `NR_REGS`=16:
  - addi x16,x0,1 (0x00100813) → `halt_code`=10, no commit.
  - Separately, addi x0,x0,1 (0x00100013) → x0 reads 0.
  - 0x00002003 (lw) → `halt_code`=10.
- Assert `rst` during an EXEC of addi x1,x0,7 → x1 stays 0, `pc`=0x80000000, state FETCH after deassert.
